contador_ctrl: RTL and testbench

Run/pause/stop sequencer for the board's free-running LED counter datapath: owns the counter register, advances it at a prescaled rate and lets the two push-buttons control it. Takes raw KEY buttons and a direction switch from the top level, synchronizes and debounces them, runs a 3-state FSM and drives the count, tick and wrap outputs. The top level maps `count_o[DATA_WIDTH-1:DATA_WIDTH-8]` to LED.

---
 rtl/contador_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_contador_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_ctrl.sv
// Run/pause/stop sequencer for the LED counter: synchronizes and debounces the
// push-buttons and direction switch, runs the IDLE/RUN/PAUSE FSM and steps the counter.
module contador_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int PRESCALE        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_start_n,
    input  logic                  key_stop_n,
    input  logic                  dir_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic [1:0]            state_o,
    output logic                  tick_o,
    output logic                  wrap_o
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PS_W-1:0]       PS_MAX   = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]       PS_ZERO  = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]       PS_ONE   = {{(PS_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W-1:0]       DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]       DB_ZERO  = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]       DB_ONE   = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] CNT_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] CNT_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] CNT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Key vectors: bit 0 = start, bit 1 = stop.
    logic [1:0]      key_meta_r;
    logic [1:0]      key_sync_r;
    logic [1:0]      key_deb_r;
    logic [1:0]      key_deb_prev_r;
    logic [DB_W-1:0] db_cnt_r [2];
    logic            dir_meta_r;
    logic            dir_sync_r;

    logic [1:0]      press_s;
    logic            start_press_s;
    logic            stop_press_s;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [DATA_WIDTH-1:0] count_r;
    logic [DATA_WIDTH-1:0] count_nxt_s;
    logic [PS_W-1:0]       presc_r;
    logic [PS_W-1:0]       presc_nxt_s;
    logic                  tick_r;
    logic                  tick_nxt_s;
    logic                  wrap_r;
    logic                  wrap_nxt_s;

    // Two-flop synchronizers for the asynchronous buttons and switch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_r <= 2'b11;
            key_sync_r <= 2'b11;
            dir_meta_r <= 1'b0;
            dir_sync_r <= 1'b0;
        end else begin
            key_meta_r <= {key_stop_n, key_start_n};
            key_sync_r <= key_meta_r;
            dir_meta_r <= dir_i;
            dir_sync_r <= dir_meta_r;
        end
    end

    // Per-key debounce: accept the synced level after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_deb_r      <= 2'b11;
            key_deb_prev_r <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt_r[k] <= DB_ZERO;
            end
        end else begin
            key_deb_prev_r <= key_deb_r;
            for (int k = 0; k < 2; k++) begin
                if (key_sync_r[k] == key_deb_r[k]) begin
                    db_cnt_r[k] <= DB_ZERO;
                end else if (db_cnt_r[k] == DB_MAX) begin
                    db_cnt_r[k]  <= DB_ZERO;
                    key_deb_r[k] <= key_sync_r[k];
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k] + DB_ONE;
                end
            end
        end
    end

    // A press is a one-cycle debounced 1->0 transition; releases are ignored.
    assign press_s       = key_deb_prev_r & ~key_deb_r;
    assign start_press_s = press_s[0];
    assign stop_press_s  = press_s[1];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; stop has priority over start.
    always_comb begin
        state_nxt_s = state_r;
        if (stop_press_s) begin
            state_nxt_s = ST_IDLE;
        end else if (start_press_s) begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_RUN;
                ST_RUN:   state_nxt_s = ST_PAUSE;
                ST_PAUSE: state_nxt_s = ST_RUN;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM output logic: prescaler, counter step, tick and wrap for the next cycle.
    always_comb begin
        count_nxt_s = count_r;
        presc_nxt_s = presc_r;
        tick_nxt_s  = 1'b0;
        wrap_nxt_s  = 1'b0;
        if (stop_press_s) begin
            count_nxt_s = CNT_ZERO;
            presc_nxt_s = PS_ZERO;
        end else if (state_r == ST_RUN) begin
            if (presc_r == PS_MAX) begin
                presc_nxt_s = PS_ZERO;
                tick_nxt_s  = 1'b1;
                if (dir_sync_r) begin
                    count_nxt_s = count_r - CNT_ONE;
                    wrap_nxt_s  = (count_r == CNT_ZERO);
                end else begin
                    count_nxt_s = count_r + CNT_ONE;
                    wrap_nxt_s  = (count_r == CNT_ONES);
                end
            end else begin
                presc_nxt_s = presc_r + PS_ONE;
            end
        end else if (state_r == ST_IDLE) begin
            presc_nxt_s = PS_ZERO;
        end else begin
            // PAUSE keeps the prescaler phase so resuming continues the same step period.
            presc_nxt_s = presc_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            presc_r <= PS_ZERO;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            presc_r <= presc_nxt_s;
            tick_r  <= tick_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign count_o = count_r;
    assign state_o = state_r;
    assign tick_o  = tick_r;
    assign wrap_o  = wrap_r;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl with DATA_WIDTH=8, PRESCALE=4, DEBOUNCE_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_contador_ctrl;

    logic       clk;
    logic       reset;
    logic       key_start_n;
    logic       key_stop_n;
    logic       dir_i;
    logic [7:0] count_o;
    logic [1:0] state_o;
    logic       tick_o;
    logic       wrap_o;

    logic [11:0] obs_s;
    logic [11:0] exp_v;
    int          checks = 0;
    int          errors = 0;

    contador_ctrl #(
        .DATA_WIDTH      (8),
        .PRESCALE        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_start_n (key_start_n),
        .key_stop_n  (key_stop_n),
        .dir_i       (dir_i),
        .count_o     (count_o),
        .state_o     (state_o),
        .tick_o      (tick_o),
        .wrap_o      (wrap_o)
    );

    // {state, count, tick, wrap}
    assign obs_s = {state_o, count_o, tick_o, wrap_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        step(2);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL reset_state: got %h want %h", obs_s, exp_v); end
        reset = 1'b1;
        step(5);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL idle_after_reset: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_run;
        key_start_n = 1'b0;
        step(5);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_latency_early: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b01, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_enter: got %h want %h", obs_s, exp_v); end
        step(3);
        exp_v = {2'b01, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_pre_step1: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b01, 8'h01, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_step1: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        step(1);
        exp_v = {2'b01, 8'h01, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_tick_width: got %h want %h", obs_s, exp_v); end
        step(3);
        exp_v = {2'b01, 8'h02, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_step2: got %h want %h", obs_s, exp_v); end
        step(4);
        exp_v = {2'b01, 8'h03, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL run_step3: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_glitch_pause_resume;
        key_start_n = 1'b0;
        step(2);
        key_start_n = 1'b1;
        step(2);
        exp_v = {2'b01, 8'h04, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL glitch_step: got %h want %h", obs_s, exp_v); end
        step(4);
        exp_v = {2'b01, 8'h05, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL glitch_ignored: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b0;
        step(6);
        exp_v = {2'b10, 8'h06, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL pause_enter: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        step(10);
        exp_v = {2'b10, 8'h06, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL pause_hold: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b0;
        step(6);
        exp_v = {2'b01, 8'h06, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL resume_enter: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b01, 8'h06, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL resume_phase: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b01, 8'h07, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL resume_step: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
    endtask

    task automatic test_stop_on_step;
        step(2);
        key_stop_n = 1'b0;
        step(5);
        exp_v = {2'b01, 8'h08, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL stop_pre: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL stop_beats_step: got %h want %h", obs_s, exp_v); end
        key_stop_n = 1'b1;
        step(5);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL stop_idle_hold: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_wrap_down;
        dir_i = 1'b1;
        step(3);
        key_start_n = 1'b0;
        step(6);
        exp_v = {2'b01, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL down_enter: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        step(4);
        exp_v = {2'b01, 8'hFF, 1'b1, 1'b1}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL down_wrap: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b01, 8'hFF, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL down_wrap_width: got %h want %h", obs_s, exp_v); end
        step(3);
        exp_v = {2'b01, 8'hFE, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL down_step2: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_wrap_up;
        dir_i = 1'b0;
        step(4);
        exp_v = {2'b01, 8'hFF, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL up_no_wrap: got %h want %h", obs_s, exp_v); end
        step(4);
        exp_v = {2'b01, 8'h00, 1'b1, 1'b1}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL up_wrap: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_start_stop_same;
        step(15);
        key_start_n = 1'b0;
        step(5);
        exp_v = {2'b01, 8'h05, 1'b1, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL pause5_step: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b10, 8'h05, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL pause5_enter: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        step(8);
        key_start_n = 1'b0;
        key_stop_n  = 1'b0;
        step(5);
        exp_v = {2'b10, 8'h05, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL both_pre: got %h want %h", obs_s, exp_v); end
        step(1);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL both_stop_wins: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        key_stop_n  = 1'b1;
        step(8);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL both_idle_hold: got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_async_reset;
        key_start_n = 1'b0;
        step(6);
        exp_v = {2'b01, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL ar_run: got %h want %h", obs_s, exp_v); end
        key_start_n = 1'b1;
        step(5);
        exp_v = {2'b01, 8'h01, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL ar_pre_reset: got %h want %h", obs_s, exp_v); end
        #2;
        reset = 1'b0;
        #1;
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL async_reset_now: got %h want %h", obs_s, exp_v); end
        step(2);
        reset = 1'b1;
        step(10);
        exp_v = {2'b00, 8'h00, 1'b0, 1'b0}; checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL after_reset_idle: got %h want %h", obs_s, exp_v); end
    endtask

    initial begin
        reset       = 1'b0;
        key_start_n = 1'b1;
        key_stop_n  = 1'b1;
        dir_i       = 1'b0;
        test_reset;
        test_run;
        test_glitch_pause_resume;
        test_stop_on_step;
        test_wrap_down;
        test_wrap_up;
        test_start_stop_same;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
